// File: rtl/sort_seq_pkg.sv
// Shared types and constants for the sort_sequencer block.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
// Contents: DATA_W word width, FSM state type, sort_cycles(n) = SORT phase length.
package sort_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} sort_state_t;

    // Number of compare-exchange cycles odd-even transposition needs for n words.
    function automatic int sort_cycles(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/sorter.sv
// Compare-exchange cell: orders two unsigned words into min/max.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: i_a, i_b operands; o_min, o_max ordered results.
module sorter
    import sort_seq_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_max,
    output logic [DATA_W-1:0] o_min
);

    logic w_swap;

    // Strict compare: equal operands pass straight through unswapped.
    assign w_swap = i_a > i_b;
    assign o_min  = w_swap ? i_b : i_a;
    assign o_max  = w_swap ? i_a : i_b;

endmodule

// File: rtl/sort_sequencer.sv
// Block sorter: loads N words, sorts in place by odd-even transposition, drains ascending.
// Latency: N(N-1)/2 cycles of SORT after the Nth accept; out_valid in the next cycle.
// Backpressure: in_ready only in LOAD; out_valid only in DRAIN, data held while out_ready=0.
// Ports: clk/rst_n; in_valid/in_ready/in_data input stream;
//        out_valid/out_ready/out_data/out_last output stream; busy high in SORT and DRAIN.
module sort_sequencer
    import sort_seq_pkg::*;
#(
    parameter int N = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int IDX_W = $clog2(N);

    if ((N < 2) || ((N % 2) != 0)) begin : g_bad_n
        $error("sort_sequencer: N must be even and >= 2");
    end

    sort_state_t       r_state, w_next_state;
    logic [DATA_W-1:0] r_mem [N];
    logic [IDX_W-1:0]  r_wr_idx, r_rd_idx, r_pass, r_pair;
    logic [IDX_W-1:0]  w_lo, w_hi;
    logic [DATA_W-1:0] w_a, w_b, w_min, w_max;
    logic              w_in_fire, w_out_fire;
    logic              w_last_wr, w_last_rd, w_last_pair, w_last_pass;

    assign w_in_fire  = (r_state == LOAD) && in_valid;
    assign w_out_fire = (r_state == DRAIN) && out_ready;
    assign w_last_wr  = (r_wr_idx == IDX_W'(N - 1));
    assign w_last_rd  = (r_rd_idx == IDX_W'(N - 1));

    // Odd passes start one word in, so they hold one pair fewer.
    assign w_last_pair = r_pass[0] ? (r_pair == IDX_W'(N / 2 - 2))
                                   : (r_pair == IDX_W'(N / 2 - 1));
    // With N=2 the only odd pass is empty, so pass 0 already finishes the sort.
    assign w_last_pass = (r_pass == IDX_W'(N - 1)) ||
                         ((N == 2) && (r_pass == IDX_W'(N - 2)));

    // Lower operand index = 2*pair + pass parity.
    assign w_lo = IDX_W'({r_pair, r_pass[0]});
    assign w_hi = w_lo + IDX_W'(1);
    assign w_a  = r_mem[w_lo];
    assign w_b  = r_mem[w_hi];

    sorter u_cell (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_max (w_max),
        .o_min (w_min)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_in_fire && w_last_wr)       w_next_state = SORT;
            SORT:    if (w_last_pair && w_last_pass)   w_next_state = DRAIN;
            DRAIN:   if (w_out_fire && w_last_rd)      w_next_state = LOAD;
            default:                                   w_next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_pass   <= '0;
            r_pair   <= '0;
            for (int k = 0; k < N; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_mem[r_wr_idx] <= in_data;
                        if (w_last_wr) begin
                            r_wr_idx <= '0;
                            r_pass   <= '0;
                            r_pair   <= '0;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                        end
                    end
                end
                SORT: begin
                    r_mem[w_lo] <= w_min;
                    r_mem[w_hi] <= w_max;
                    if (w_last_pair) begin
                        r_pair <= '0;
                        if (w_last_pass) begin
                            r_pass   <= '0;
                            r_rd_idx <= '0;
                        end else begin
                            r_pass <= r_pass + IDX_W'(1);
                        end
                    end else begin
                        r_pair <= r_pair + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        r_rd_idx <= w_last_rd ? '0 : r_rd_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == DRAIN);
    assign busy      = (r_state != LOAD);
    assign out_data  = (r_state == DRAIN) ? r_mem[r_rd_idx] : '0;
    assign out_last  = (r_state == DRAIN) && w_last_rd;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer: N=8 instance for the main scenarios, N=2 instance for the minimum size.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_sort_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [7:0] b_in_data, b_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] stim [8];
    logic [7:0] expv [8];

    sort_sequencer #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy)
    );

    sort_sequencer #(.N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy)
    );

    // Present stim[] as 8 back-to-back words; returns 1 unit after the 8th accept edge.
    task automatic load_a(input string name);
        int not_ready = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_in_ready !== 1'b1) not_ready++;
            a_in_valid = 1'b1;
            a_in_data  = stim[i];
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        n_checks++;
        if (not_ready !== 0) begin
            n_fail++;
            $display("FAIL %s load_in_ready: %0d cycles not ready, required 0", name, not_ready);
        end
    endtask

    // Count edges from the 8th accept until out_valid is seen.
    task automatic wait_sort_a(input string name, input int exp_cycles, input bit noisy);
        int n = 0;
        int bad = 0;
        while (a_out_valid !== 1'b1 && n < 200) begin
            if (a_in_ready !== 1'b0 || a_busy !== 1'b1) bad++;
            if (noisy) begin
                a_in_valid = 1'b1;
                a_in_data  = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s sort_latency: got %0d cycles, required %0d", name, n, exp_cycles);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s sort_flags: %0d cycles with in_ready/busy wrong, required 0", name, bad);
        end
    endtask

    // Drain and compare against expv[]; optional random out_ready and input noise.
    task automatic drain_a(input string name, input bit rnd_ready, input bit noisy);
        int idx = 0;
        int cyc = 0;
        int stab_bad = 0;
        int ir_bad = 0;
        bit stalled = 1'b0;
        logic [7:0] prev = 8'h00;
        logic prev_last = 1'b0;
        while (idx < 8 && cyc < 300) begin
            if (a_in_ready !== 1'b0) ir_bad++;
            if (stalled && (a_out_data !== prev || a_out_last !== prev_last || a_out_valid !== 1'b1))
                stab_bad++;
            a_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noisy) begin
                a_in_valid = 1'b1;
                a_in_data  = 8'($urandom);
            end
            if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
                n_checks++;
                if (a_out_data !== expv[idx] || a_out_last !== (idx == 7)) begin
                    n_fail++;
                    $display("FAIL %s word%0d: got data %0h last %0b, required data %0h last %0b",
                             name, idx, a_out_data, a_out_last, expv[idx], (idx == 7));
                end
                idx++;
                stalled = 1'b0;
            end else begin
                stalled   = (a_out_valid === 1'b1);
                prev      = a_out_data;
                prev_last = a_out_last;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        n_checks++;
        if (idx !== 8) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d words, required 8", name, idx);
        end
        n_checks++;
        if (stab_bad !== 0 || ir_bad !== 0) begin
            n_fail++;
            $display("FAIL %s drain_stability: %0d unstable stalls, %0d in_ready highs, required 0/0",
                     name, stab_bad, ir_bad);
        end
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back_to_load: got in_ready %0b out_valid %0b busy %0b, required 1 0 0",
                     name, a_in_ready, a_out_valid, a_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_during_n8: got rdy %0b vld %0b data %0h last %0b busy %0b, required 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy);
        end
        n_checks++;
        if ({b_in_ready, b_out_valid, b_out_data, b_out_last, b_busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_during_n2: got rdy %0b vld %0b data %0h last %0b busy %0b, required 1 0 0 0 0",
                     b_in_ready, b_out_valid, b_out_data, b_out_last, b_busy);
        end
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_after: got rdy %0b vld %0b data %0h last %0b busy %0b, required 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy);
        end
    endtask

    task automatic test_reverse();
        stim = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        expv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_a("reverse");
        wait_sort_a("reverse", 28, 1'b0);
        drain_a("reverse", 1'b0, 1'b0);
    endtask

    task automatic test_duplicates();
        stim = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F};
        expv = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF};
        load_a("dups");
        wait_sort_a("dups", 28, 1'b0);
        drain_a("dups", 1'b0, 1'b0);
    endtask

    task automatic test_sorted();
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        expv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_a("sorted");
        wait_sort_a("sorted", 28, 1'b0);
        drain_a("sorted", 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        stim = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4};
        expv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
        load_a("bp");
        wait_sort_a("bp", 28, 1'b0);
        drain_a("bp", 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_sort();
        stim = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_a("midrst");
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rdy %0b vld %0b data %0h last %0b busy %0b, required 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stim = '{8'd3, 8'd1, 8'd2, 8'd6, 8'd5, 8'd4, 8'd7, 8'd0};
        expv = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        load_a("postrst");
        wait_sort_a("postrst", 28, 1'b0);
        drain_a("postrst", 1'b0, 1'b0);
    endtask

    task automatic test_ignored_input();
        stim = '{8'd4, 8'd8, 8'd2, 8'd6, 8'd1, 8'd7, 8'd3, 8'd5};
        expv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_a("noisy");
        wait_sort_a("noisy", 28, 1'b1);
        drain_a("noisy", 1'b1, 1'b1);
    endtask

    task automatic test_n2();
        int n = 0;
        b_in_valid = 1'b1;
        b_in_data  = 8'd9;
        @(posedge clk); #1;
        b_in_data  = 8'd4;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        while (b_out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL n2_latency: got %0d cycles, required 1", n);
        end
        b_out_ready = 1'b1;
        n_checks++;
        if (b_out_data !== 8'd4 || b_out_last !== 1'b0 || b_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL n2_word0: got data %0d last %0b valid %0b, required 4 0 1", b_out_data, b_out_last, b_out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (b_out_data !== 8'd9 || b_out_last !== 1'b1 || b_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL n2_word1: got data %0d last %0b valid %0b, required 9 1 1", b_out_data, b_out_last, b_out_valid);
        end
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        n_checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL n2_back_to_load: got in_ready %0b out_valid %0b, required 1 0", b_in_ready, b_out_valid);
        end
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
        test_reset();
        test_reverse();
        test_duplicates();
        test_sorted();
        test_backpressure();
        test_reset_mid_sort();
        test_ignored_input();
        test_n2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
